deparser_field_writer: RTL and testbench
========================================

# deparser_field_writer

Pipelined deparser placed after the parser layers and the match/action stages. It takes the tagged head stream and the packet's metadata, and writes up to 8 configurable 16-bit fields from the metadata back into the header bytes at programmed offsets. Header slices, metadata and tags pass through with a fixed 2-cycle latency. Its rule registers sit on the same rule configuration bus as the parser layers and are selected by their own layer ID.

## Interface
- HEAD_WIDTH, 512: data bits per head slice, i.e. 64 bytes per slice.
- META_WIDTH, 512: metadata bits. Field i is sourced from meta[i*16 +: 16].
- TAG_WIDTH, 9: tag layout is {valid[8], start[7], tail[6], offset[5:0]}. offset is the index of the last valid byte in the slice.
- FIELD_NUM, 8: number of writable fields.
- LAYER_ID, 8'h10: rule_addr[31:24] value that selects this block.
- i_clk  in  1  clock.
- i_rst  in  1  reset. One clock; reset is synchronous and active-high.
- i_rule_wren  in  1  rule write strobe.
- i_rule_rden  in  1  rule read strobe.
- i_rule_addr  in  32  [31:24] layer ID; [2:0] field index.
- i_rule_wdata  in  32  [16] enable; [7:0] absolute header byte offset (0..255).
- o_rule_rdata_valid  out  1  readback valid.
- o_rule_rdata  out  32  readback {15'b0, enable, 8'b0, offset}.
- i_head  in  HEAD_WIDTH+TAG_WIDTH  {tag, data}. Byte 0 of a slice is data[HEAD_WIDTH-1 -: 8].
- o_head  out  HEAD_WIDTH+TAG_WIDTH  rewritten head.
- i_meta  in  META_WIDTH+TAG_WIDTH  {tag, meta}. The start slice arrives in the same cycle as the head start slice.
- o_meta  out  META_WIDTH+TAG_WIDTH  delayed meta, not modified.

## Operation
- Config registers: FIELD_NUM entries of {en, off[7:0]}.
  - A write is accepted when i_rule_wren=1 and addr[31:24]=LAYER_ID.
  - A read is accepted when i_rule_rden=1 and addr[31:24]=LAYER_ID. It returns the entry at addr[2:0] one cycle later, with o_rule_rdata_valid high for exactly 1 cycle.
  - Reads or writes with any other layer ID are ignored.
- Packet state:
  - active flag, slice index sidx[1:0], 2-bit saturating at 3, covering headers up to 256 bytes.
  - Snapshot of config and meta fields taken at the start slice.
- Stage 1, register the input slice:
  - A slice with valid=1 and start=1 sets active=1, sidx=0, and loads the config snapshot and the 8 meta fields.
  - A slice with valid=1 and start=0 increments sidx, saturating at 3.
  - A slice with valid=1 and tail=1 clears active after it is processed.
- Stage 2, per-byte write. For each enabled field i and byte b ∈ {0,1}, let abs = off_i + b (9-bit, no wrap).
  - The byte is written when active, abs[8:6] == sidx, and abs[5:0] ≤ tag.offset.
  - Field byte 0 is the MSB of the 16-bit field.
  - Fields may straddle a slice boundary: each byte is written independently, one in slice k and the other in slice k+1.
  - abs ≥ 256 is never written.
  - If two fields cover the same byte, the higher field index wins.
- Slice with valid=0: passes through unmodified and does not change sidx or active.
- Slice with valid=1 and start=0 while active=0 (orphan): passes through unmodified.
- A new start while active: the previous packet is abandoned, and the snapshot and sidx are reloaded.
- Config writes during a packet affect only packets whose start slice enters after the write cycle.

## Timing
- Latency: o_head and o_meta equal i_head and i_meta (with rewrites) exactly 2 cycles later. Throughput is 1 slice per cycle, with no backpressure.
- Readback latency is 1 cycle. A read and a write to the same entry in the same cycle returns the old value.
- Reset values:
  - o_head=0, o_meta=0, o_rule_rdata_valid=0, o_rule_rdata=0.
  - All config entries are en=0, off=0.
  - active=0, sidx=0, and both pipeline stages are cleared.
- Reset asserted mid-packet: the pipeline is flushed to zeros on the next edge. Slices after reset deassertion that are not preceded by a start pass through unmodified.

## Test plan
- Basic rewrite: field 0 = {en=1, off=12}; meta[15:0]=16'h86DD. Send a 64-byte single-slice packet (start, tail, offset=63) with data bytes 12 and 13 = 08 00 → 2 cycles later, bytes 12 and 13 = 86 DD and all other bits are unchanged.
- Slice straddle: field 3 = {en=1, off=63}; meta[63:48]=16'hABCD; two-slice packet → slice 0 byte 63 = AB, slice 1 byte 0 = CD.
- Tail bound: field 1 at off=70; tail slice 1 has offset=5 (last valid abs byte 69) → no bytes written. With offset=7 → bytes 6 and 7 of slice 1 are written.
- Overlap and disable: fields 2 and 5 both at off=20, field 5 value 16'h1111 → 11 11 written. Disable field 5 → field 2 value written.
- Config timing: start packet A, write field 0 off=30 during A's second slice, then send packet B → A uses the old offset and B uses 30. Readback of field 0 → o_rule_rdata=32'h0001001E, valid one cycle after i_rule_rden.
- Reset and orphan: assert i_rst mid-packet → o_head=0 for the flushed cycles. A continuation slice following reset passes through unmodified.

Source files
------------

// File: rtl/deparser_field_writer.sv
// Deparser stage: writes up to FIELD_NUM 16-bit metadata fields back into the
// header byte stream at programmed absolute offsets, with a fixed 2-cycle latency.
module deparser_field_writer #(
  parameter int         HEAD_WIDTH = 512,
  parameter int         META_WIDTH = 512,
  parameter int         TAG_WIDTH  = 9,
  parameter int         FIELD_NUM  = 8,
  parameter logic [7:0] LAYER_ID   = 8'h10
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_rule_wren,
  input  logic                            i_rule_rden,
  input  logic [31:0]                     i_rule_addr,
  input  logic [31:0]                     i_rule_wdata,
  output logic                            o_rule_rdata_valid,
  output logic [31:0]                     o_rule_rdata,
  input  logic [HEAD_WIDTH+TAG_WIDTH-1:0] i_head,
  output logic [HEAD_WIDTH+TAG_WIDTH-1:0] o_head,
  input  logic [META_WIDTH+TAG_WIDTH-1:0] i_meta,
  output logic [META_WIDTH+TAG_WIDTH-1:0] o_meta
);

  localparam int HW = HEAD_WIDTH + TAG_WIDTH;
  localparam int MW = META_WIDTH + TAG_WIDTH;

  function automatic logic [1:0] sidx_sat_inc(input logic [1:0] s);
    return (s == 2'd3) ? 2'd3 : s + 2'd1;
  endfunction

  function automatic logic [HEAD_WIDTH-1:0] put_byte(input logic [HEAD_WIDTH-1:0] d,
                                                     input logic [5:0] idx,
                                                     input logic [7:0] v);
    logic [HEAD_WIDTH-1:0] r;
    r = d;
    r[HEAD_WIDTH - 8 - 8 * int'(idx) +: 8] = v;
    return r;
  endfunction

  logic [TAG_WIDTH-1:0] in_tag;
  logic                 in_vld, in_start, in_tail;
  assign in_tag   = i_head[HW-1 -: TAG_WIDTH];
  assign in_vld   = in_tag[8];
  assign in_start = in_tag[7];
  assign in_tail  = in_tag[6];

  logic       rule_hit;
  logic [2:0] rule_idx;
  logic       unused_rule;
  assign rule_hit    = (i_rule_addr[31:24] == LAYER_ID);
  assign rule_idx    = i_rule_addr[2:0];
  assign unused_rule = ^{i_rule_addr[23:3], i_rule_wdata[31:17], i_rule_wdata[15:8]};

  logic       cfg_en  [FIELD_NUM];
  logic [7:0] cfg_off [FIELD_NUM];

  // Rule registers; a same-cycle read sees the pre-write value
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < FIELD_NUM; i++) begin
        cfg_en[i]  <= 1'b0;
        cfg_off[i] <= '0;
      end
      o_rule_rdata_valid <= 1'b0;
      o_rule_rdata       <= '0;
    end else begin
      if (i_rule_wren && rule_hit) begin
        cfg_en[rule_idx]  <= i_rule_wdata[16];
        cfg_off[rule_idx] <= i_rule_wdata[7:0];
      end
      o_rule_rdata_valid <= i_rule_rden && rule_hit;
      if (i_rule_rden && rule_hit)
        o_rule_rdata <= {15'b0, cfg_en[rule_idx], 8'b0, cfg_off[rule_idx]};
    end
  end

  logic [HW-1:0] head_p1;
  logic [MW-1:0] meta_p1;
  logic          act_p1;
  logic [1:0]    sidx_p1;
  logic          pkt_active;
  logic [1:0]    pkt_sidx;
  logic          snap_en  [FIELD_NUM];
  logic [7:0]    snap_off [FIELD_NUM];
  logic [15:0]   snap_val [FIELD_NUM];

  // Stage 1: register slice, track packet position, snapshot rules/meta on start
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      head_p1    <= '0;
      meta_p1    <= '0;
      act_p1     <= 1'b0;
      sidx_p1    <= '0;
      pkt_active <= 1'b0;
      pkt_sidx   <= '0;
      for (int i = 0; i < FIELD_NUM; i++) begin
        snap_en[i]  <= 1'b0;
        snap_off[i] <= '0;
        snap_val[i] <= '0;
      end
    end else begin
      head_p1 <= i_head;
      meta_p1 <= i_meta;
      act_p1  <= in_vld && (in_start || pkt_active);
      sidx_p1 <= in_start ? 2'd0 : sidx_sat_inc(pkt_sidx);
      if (in_vld) begin
        pkt_active <= (in_start || pkt_active) && !in_tail;
        if (in_start) begin
          pkt_sidx <= 2'd0;
          for (int i = 0; i < FIELD_NUM; i++) begin
            snap_en[i]  <= cfg_en[i];
            snap_off[i] <= cfg_off[i];
            snap_val[i] <= i_meta[i*16 +: 16];
          end
        end else if (pkt_active) begin
          pkt_sidx <= sidx_sat_inc(pkt_sidx);
        end
      end
    end
  end

  logic [5:0]            last_p1;
  logic [8:0]            abs_byte;
  logic [HEAD_WIDTH-1:0] wr_data;
  assign last_p1 = head_p1[HEAD_WIDTH +: 6];

  // Ascending field order lets the higher index win on overlapping bytes
  always_comb begin
    wr_data  = head_p1[HEAD_WIDTH-1:0];
    abs_byte = '0;
    for (int i = 0; i < FIELD_NUM; i++) begin
      for (int b = 0; b < 2; b++) begin
        abs_byte = {1'b0, snap_off[i]} + 9'(b);
        if (act_p1 && snap_en[i] && (abs_byte[8:6] == {1'b0, sidx_p1}) &&
            (abs_byte[5:0] <= last_p1))
          wr_data = put_byte(wr_data, abs_byte[5:0],
                             (b == 0) ? snap_val[i][15:8] : snap_val[i][7:0]);
      end
    end
  end

  // Stage 2: rewritten slice out
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_head <= '0;
      o_meta <= '0;
    end else begin
      o_head <= {head_p1[HW-1 -: TAG_WIDTH], wr_data};
      o_meta <= meta_p1;
    end
  end

endmodule

// File: tb/tb_deparser_field_writer.sv
// Bench for deparser_field_writer: byte-level packet model plus directed
// vectors with hand-computed byte expectations.
module tb_deparser_field_writer;
  localparam int W = 521;

  logic          i_clk = 1'b0;
  logic          i_rst, i_rule_wren, i_rule_rden;
  logic [31:0]   i_rule_addr, i_rule_wdata;
  logic          o_rule_rdata_valid;
  logic [31:0]   o_rule_rdata;
  logic [W-1:0]  i_head, o_head, i_meta, o_meta;

  always #5 i_clk = ~i_clk;

  deparser_field_writer dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_rule_wren(i_rule_wren), .i_rule_rden(i_rule_rden),
    .i_rule_addr(i_rule_addr), .i_rule_wdata(i_rule_wdata),
    .o_rule_rdata_valid(o_rule_rdata_valid), .o_rule_rdata(o_rule_rdata),
    .i_head(i_head), .o_head(o_head), .i_meta(i_meta), .o_meta(o_meta)
  );

  int checks = 0;
  int errors = 0;

  // model state
  logic        m_en [8];
  logic [7:0]  m_off [8];
  logic        s_en [8];
  logic [7:0]  s_off [8];
  logic [15:0] s_val [8];
  bit          m_act;
  int          m_sidx;
  logic [31:0] m_rd;

  logic [W-1:0] d1_head, d1_meta, out_head, out_meta;
  int           d1_id = -1, out_id = -1, next_id = 0;
  logic         out_rv;
  logic [31:0]  out_rd;
  bit           chk_en = 0;
  logic [511:0] obs [int];

  function automatic logic [511:0] setb(input logic [511:0] d, input int k, input logic [7:0] v);
    d[511 - 8*k -: 8] = v;
    return d;
  endfunction

  function automatic logic [7:0] getb(input logic [511:0] d, input int k);
    return d[511 - 8*k -: 8];
  endfunction

  function automatic logic [511:0] pat(input int seed);
    logic [511:0] d;
    d = '0;
    for (int k = 0; k < 64; k++) d = setb(d, k, 8'((seed * 7 + k) & 255));
    return d;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_en[i] = 0; m_off[i] = 0; s_en[i] = 0; s_off[i] = 0; s_val[i] = 0;
    end
    m_act = 0; m_sidx = 0; m_rd = 0;
  endtask

  // Expected output slice: bytes land where absolute packet byte position
  // (slice*64 + byte) equals field offset + byte-in-field.
  task automatic model_slice(input logic [W-1:0] h, input logic [W-1:0] m, output logic [W-1:0] e);
    logic [8:0]   tag;
    logic [511:0] d;
    int           pos, last;
    bit           wr;
    tag = h[520:512];
    d = h[511:0];
    last = int'(tag[5:0]);
    wr = 0;
    if (tag[8]) begin
      if (tag[7]) begin
        m_act = 1; m_sidx = 0;
        for (int i = 0; i < 8; i++) begin
          s_en[i] = m_en[i]; s_off[i] = m_off[i]; s_val[i] = m[i*16 +: 16];
        end
      end else if (m_act && m_sidx < 3) begin
        m_sidx++;
      end
      wr = m_act;
    end
    if (wr)
      for (int i = 0; i < 8; i++)
        for (int b = 0; b < 2; b++) begin
          pos = int'(s_off[i]) + b;
          if (s_en[i] && pos < 256 && pos / 64 == m_sidx && pos % 64 <= last)
            d = setb(d, pos % 64, (b == 0) ? s_val[i][15:8] : s_val[i][7:0]);
        end
    if (tag[8] && tag[6]) m_act = 0;
    e = {tag, d};
  endtask

  task automatic tick(input logic rst, input logic wren, input logic rden,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [W-1:0] h, input logic [W-1:0] m, output int id);
    logic [W-1:0] e;
    logic         e_rv;
    logic [31:0]  e_rd;
    logic         hit;
    i_rst = rst; i_rule_wren = wren; i_rule_rden = rden;
    i_rule_addr = addr; i_rule_wdata = wdata; i_head = h; i_meta = m;
    id = next_id++;
    model_slice(h, m, e);
    hit = (addr[31:24] == 8'h10);
    e_rv = rden && hit;
    if (e_rv) m_rd = {15'b0, m_en[addr[2:0]], 8'b0, m_off[addr[2:0]]};
    e_rd = m_rd;
    if (wren && hit) begin
      m_en[addr[2:0]] = wdata[16];
      m_off[addr[2:0]] = wdata[7:0];
    end
    if (rst) model_reset();
    @(posedge i_clk);
    if (rst) begin
      out_head = '0; out_meta = '0; out_id = -1;
      d1_head = '0; d1_meta = '0; d1_id = -1;
      out_rv = 0; out_rd = '0;
    end else begin
      out_head = d1_head; out_meta = d1_meta; out_id = d1_id;
      d1_head = e; d1_meta = m; d1_id = id;
      out_rv = e_rv; out_rd = e_rd;
    end
    #1;
  endtask

  task automatic slice(input logic [8:0] tag, input logic [511:0] d, input logic [511:0] m, output int id);
    tick(0, 0, 0, 32'h0, 32'h0, {tag, d}, {tag, m}, id);
  endtask

  task automatic wr(input logic [2:0] idx, input logic en, input logic [7:0] off);
    int id;
    tick(0, 1, 0, {8'h10, 21'b0, idx}, {15'b0, en, 8'b0, off}, '0, '0, id);
  endtask

  task automatic idle(input int n);
    int id;
    for (int i = 0; i < n; i++) tick(0, 0, 0, 32'h0, 32'h0, '0, '0, id);
  endtask

  task automatic chk_val(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, exp);
    end
  endtask

  task automatic chk_byte(input string nm, input int id, input int k, input logic [7:0] exp);
    logic [511:0] s;
    checks++;
    if (!obs.exists(id)) begin
      errors++;
      $display("FAIL %s no output captured for slice %0d", nm, id);
    end else begin
      s = obs[id];
      if (getb(s, k) !== exp) begin
        errors++;
        $display("FAIL %s got %h want %h", nm, getb(s, k), exp);
      end
    end
  endtask

  always @(negedge i_clk) begin
    if (chk_en) begin
      checks++;
      if (o_head !== out_head) begin
        errors++;
        $display("FAIL head slice=%0d got %h want %h", out_id, o_head, out_head);
      end
      checks++;
      if (o_meta !== out_meta) begin
        errors++;
        $display("FAIL meta slice=%0d got %h want %h", out_id, o_meta, out_meta);
      end
      checks++;
      if (o_rule_rdata_valid !== out_rv) begin
        errors++;
        $display("FAIL rdata_valid got %b want %b", o_rule_rdata_valid, out_rv);
      end
      checks++;
      if (o_rule_rdata !== out_rd) begin
        errors++;
        $display("FAIL rdata got %h want %h", o_rule_rdata, out_rd);
      end
      if (out_id >= 0) obs[out_id] = o_head[511:0];
    end
  end

  initial begin
    int id, a0, a1, b0;
    logic [511:0] d, m;

    tick(1, 0, 0, 32'h0, 32'h0, '0, '0, id);
    chk_en = 1;
    tick(1, 0, 0, 32'h0, 32'h0, '0, '0, id);
    chk_val("rst_head", o_head, '0);
    chk_val("rst_rv", W'(o_rule_rdata_valid), '0);
    chk_val("rst_rdata", W'(o_rule_rdata), '0);

    // basic rewrite
    wr(3'd0, 1, 8'd12);
    d = setb(setb(pat(0), 12, 8'h08), 13, 8'h00);
    m = '0; m[15:0] = 16'h86DD;
    slice(9'h1FF, d, m, a0);
    idle(2);
    chk_byte("basic_b12", a0, 12, 8'h86);
    chk_byte("basic_b13", a0, 13, 8'hDD);
    chk_byte("basic_b11", a0, 11, 8'h0B);
    chk_byte("basic_b14", a0, 14, 8'h0E);

    // straddle with a valid=0 bubble inside the packet
    wr(3'd3, 1, 8'd63);
    m[63:48] = 16'hABCD;
    slice(9'h1BF, pat(1), m, a0);
    slice(9'h000, pat(2), m, id);
    slice(9'h17F, pat(3), m, a1);
    idle(2);
    chk_byte("straddle_s0b63", a0, 63, 8'hAB);
    chk_byte("straddle_s1b0", a1, 0, 8'hCD);
    chk_byte("straddle_s1b1", a1, 1, 8'h16);

    // tail bound
    wr(3'd1, 1, 8'd70);
    m[31:16] = 16'h1234;
    slice(9'h1BF, pat(4), m, a0);
    slice(9'h145, pat(5), m, a1);
    idle(2);
    chk_byte("tail5_b6", a1, 6, 8'h29);
    chk_byte("tail5_b7", a1, 7, 8'h2A);
    slice(9'h1BF, pat(4), m, a0);
    slice(9'h147, pat(5), m, a1);
    idle(2);
    chk_byte("tail7_b6", a1, 6, 8'h12);
    chk_byte("tail7_b7", a1, 7, 8'h34);

    // overlap and disable
    wr(3'd2, 1, 8'd20);
    wr(3'd5, 1, 8'd20);
    m[47:32] = 16'h2222; m[95:80] = 16'h1111;
    slice(9'h1FF, pat(6), m, a0);
    idle(2);
    chk_byte("overlap_b20", a0, 20, 8'h11);
    chk_byte("overlap_b21", a0, 21, 8'h11);
    wr(3'd5, 0, 8'd20);
    slice(9'h1FF, pat(6), m, a1);
    idle(2);
    chk_byte("disable_b20", a1, 20, 8'h22);
    chk_byte("disable_b21", a1, 21, 8'h22);

    // config write during packet A only affects packet B
    m[15:0] = 16'hBEEF;
    slice(9'h1BF, pat(7), m, a0);
    tick(0, 1, 0, 32'h1000_0000, 32'h0001_001E, {9'h17F, pat(8)}, {9'h17F, m}, a1);
    slice(9'h1FF, pat(9), m, b0);
    idle(2);
    chk_byte("cfgA_b12", a0, 12, 8'hBE);
    chk_byte("cfgA_b13", a0, 13, 8'hEF);
    chk_byte("cfgB_b30", b0, 30, 8'hBE);
    chk_byte("cfgB_b31", b0, 31, 8'hEF);
    chk_byte("cfgB_b12", b0, 12, 8'h4B);

    // readback, foreign layer, read+write same cycle
    tick(0, 0, 1, 32'h1000_0000, 32'h0, '0, '0, id);
    chk_val("rd_valid", W'(o_rule_rdata_valid), W'(1));
    chk_val("rd_data", W'(o_rule_rdata), W'(32'h0001_001E));
    tick(0, 1, 0, 32'h2000_0000, 32'h0001_0050, '0, '0, id);
    chk_val("rd_valid_pulse", W'(o_rule_rdata_valid), '0);
    tick(0, 0, 1, 32'h2000_0000, 32'h0, '0, '0, id);
    chk_val("rd_foreign", W'(o_rule_rdata_valid), '0);
    tick(0, 1, 1, 32'h1000_0000, 32'h0001_0028, '0, '0, id);
    chk_val("rdwr_old", W'(o_rule_rdata), W'(32'h0001_001E));
    tick(0, 0, 1, 32'h1000_0000, 32'h0, '0, '0, id);
    chk_val("rd_new", W'(o_rule_rdata), W'(32'h0001_0028));

    // reset mid-packet, then orphan continuation
    slice(9'h1BF, pat(10), m, a0);
    tick(1, 0, 0, 32'h0, 32'h0, {9'h17F, pat(11)}, {9'h17F, m}, id);
    chk_val("flush0", o_head, '0);
    slice(9'h17F, pat(12), m, a1);
    chk_val("flush1", o_head, '0);
    idle(2);
    checks++;
    if (!obs.exists(a1) || obs[a1] !== pat(12)) begin
      errors++;
      $display("FAIL orphan_passthru slice=%0d", a1);
    end

    idle(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
